f_wb_arbiter: RTL and testbench
===============================

# f_wb_arbiter

Floating-point writeback arbiter. It sits directly upstream of the FP register file and drives its write port (`f_wen`, `f_rd`, `f_w_data`) and its exception-flag inputs (`f_NV`, `f_DZ`, `f_OF`, `f_UF`, `f_NX`). It merges two result sources:

- a single-cycle fast path (add/mul/convert/compare), which has priority;
- a multi-cycle slow path (div/sqrt), whose results are buffered in a small FIFO.

A starvation guard stalls the fast path so that slow results always drain. A hazard-query port tells the control unit whether a destination register still has a write pending.

## Interface

Parameters:
- `FIFO_DEPTH`, default 2: slow-result buffer entries, must be ≥1.
- `STARVE_LIMIT`, default 8: cycles a non-empty FIFO head may wait before the fast path is stalled, must be ≥1.

Ports:
- `clk` in 1: clock, all state on the rising edge.
- `n_rst` in 1: reset, synchronous, active-high.
- `fast_valid` in 1: fast result present this cycle.
- `fast_fwe` in 1: 1 = write FP register; 0 = flags only (e.g. compare to integer register).
- `fast_rd` in 5: destination FP register.
- `fast_data` in 32: result.
- `fast_flags` in 5: {NV,DZ,OF,UF,NX}.
- `fast_stall` out 1: upstream must hold its fast inputs; result not taken this cycle.
- `slow_valid` in 1: slow result offered.
- `slow_ready` out 1: FIFO can accept; transfer when `slow_valid && slow_ready`.
- `slow_rd` in 5: destination FP register.
- `slow_data` in 32: result.
- `slow_flags` in 5: {NV,DZ,OF,UF,NX}.
- `chk_rd` in 5: register to test for a pending write.
- `chk_hit` out 1: `chk_rd` has a pending write.
- `f_wen` out 1: register file write enable.
- `f_rd` out 5: write address.
- `f_w_data` out 32: write data.
- `f_NV`, `f_DZ`, `f_OF`, `f_UF`, `f_NX` out 1 each: flag pulses for the register file's sticky fflags.

## Operation

Output stage:
- One registered stage holds `f_wen`, `f_rd`, `f_w_data`, the five flags, and an internal `out_valid`.
- Each cycle it loads exactly one winner, or clears `out_valid`, `f_wen` and the flags if there is none.

Winner selection, in priority order:
1. If `fast_stall` = 0 and `fast_valid` = 1, the fast result wins. It loads `f_wen` = `fast_fwe`, `fast_rd`, `fast_data` and `fast_flags`.
2. Otherwise, if the FIFO is non-empty, the FIFO head wins and is popped. It loads `f_wen` = 1 and the head's rd, data and flags.
3. Otherwise there is no winner.

Flag outputs:
- Asserted only in a cycle where `out_valid` = 1, and equal to the winner's flags.
- They are presented even when `f_wen` = 0 (flags-only op).

FIFO:
- Circular buffer with a count from 0 to `FIFO_DEPTH`.
- `slow_ready` = (count < `FIFO_DEPTH`), decoded from registered state.
- A push while full is impossible by construction. A pop does not free a slot for a push in the same cycle.
- A push and a pop in the same cycle leave the count unchanged and are valid.
- Pointers wrap modulo `FIFO_DEPTH`.

Starvation counter:
- Resets to 0 whenever the FIFO is empty or its head is popped.
- Otherwise increments while `fast_valid` = 1 and the fast result wins, saturating at `STARVE_LIMIT`.
- `fast_stall` = (counter == `STARVE_LIMIT`), decoded combinationally from the register. In that cycle the head wins.

Hazard query: `chk_hit` is combinational and is 1 if either:
- any valid FIFO entry has rd == `chk_rd`, or
- `f_wen` = 1 and `f_rd` == `chk_rd`.

Register f0 is an ordinary register: writes to it proceed and it is included in `chk_hit`.

Reset (`n_rst` high at an edge):
- `f_wen`, the flags, `f_rd` and `f_w_data` go to 0.
- FIFO empties; pointers and counter go to 0.
- `slow_ready` becomes 1 and `fast_stall` becomes 0.
- Entries in flight mid-operation are discarded.

## Timing

- Fast path latency is 1: `fast_valid` at cycle t gives `f_wen`/flags at t+1.
- Slow path latency is at least 2: accepted at t, head at t+1, written at t+2 if no fast result wins at t+1.
- With back-to-back fast results and a non-empty FIFO, `fast_stall` rises after `STARVE_LIMIT` fast wins and holds for exactly 1 cycle. The head is then written on the following cycle.
- Throughput is one register-file write per cycle.
- `slow_ready` reflects the count after the previous edge.

## Test plan

- Reset, then `fast_valid` with rd=5, data=0x3F800000, flags=00001, fwe=1 → next cycle `f_wen`=1, `f_rd`=5, `f_w_data`=0x3F800000, `f_NX`=1; the cycle after, all outputs are 0.
- Slow push rd=7, data=0x40000000, flags=00010 with no fast traffic → written 2 cycles after acceptance with `f_UF`=1. `chk_hit` with `chk_rd`=7 is 1 from the cycle after acceptance through the write cycle.
- Fill the FIFO (2 pushes) while fast_valid is held → `slow_ready`=0. A third push is held until a pop. Entries write out in push order.
- Continuous `fast_valid` with FIFO non-empty → `fast_stall`=1 on the 9th cycle (limit 8). The head is written next cycle, the counter resets, and the stalled fast result writes the cycle after.
- Fast op with `fast_fwe`=0 and flags=10000 → `f_wen`=0 and `f_NV`=1 for 1 cycle.
- Assert `n_rst` with 2 entries queued and `f_wen`=1 → next cycle the FIFO is empty, `f_wen`=0, `slow_ready`=1, `chk_hit`=0 for all rd.

Source files
------------

// File: rtl/f_wb_arbiter_if.sv
// Bundle of the fast/slow result inputs, hazard query and register-file write port
// of the FP writeback arbiter. slave = arbiter side, master = surrounding pipeline.
interface f_wb_arbiter_if;
  logic        fast_valid;
  logic        fast_fwe;
  logic [4:0]  fast_rd;
  logic [31:0] fast_data;
  logic [4:0]  fast_flags;
  logic        fast_stall;

  logic        slow_valid;
  logic        slow_ready;
  logic [4:0]  slow_rd;
  logic [31:0] slow_data;
  logic [4:0]  slow_flags;

  logic [4:0]  chk_rd;
  logic        chk_hit;

  logic        f_wen;
  logic [4:0]  f_rd;
  logic [31:0] f_w_data;
  logic        f_NV;
  logic        f_DZ;
  logic        f_OF;
  logic        f_UF;
  logic        f_NX;

  modport slave (
    input  fast_valid, fast_fwe, fast_rd, fast_data, fast_flags,
    output fast_stall,
    input  slow_valid, slow_rd, slow_data, slow_flags,
    output slow_ready,
    input  chk_rd,
    output chk_hit,
    output f_wen, f_rd, f_w_data, f_NV, f_DZ, f_OF, f_UF, f_NX
  );

  modport master (
    output fast_valid, fast_fwe, fast_rd, fast_data, fast_flags,
    input  fast_stall,
    output slow_valid, slow_rd, slow_data, slow_flags,
    input  slow_ready,
    output chk_rd,
    input  chk_hit,
    input  f_wen, f_rd, f_w_data, f_NV, f_DZ, f_OF, f_UF, f_NX
  );
endinterface

// File: rtl/f_wb_arbiter.sv
// FP writeback arbiter: fast single-cycle results have priority, slow div/sqrt results
// queue in a FIFO, and a starvation counter briefly stalls the fast path to drain it.
// Handshake: slow transfer happens on a rising edge where slow_valid && slow_ready;
// fast_stall=1 means the fast result is not taken and upstream holds it.
module f_wb_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic n_rst,
  f_wb_arbiter_if.slave bus
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]            mem_rd_q    [FIFO_DEPTH];
  logic [31:0]           mem_data_q  [FIFO_DEPTH];
  logic [4:0]            mem_flags_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [SW-1:0]         starv_q, starv_d;

  logic                  out_valid_q;
  logic                  f_wen_q;
  logic [4:0]            f_rd_q;
  logic [31:0]           f_w_data_q;
  logic [4:0]            flags_q;

  logic fast_stall, slow_ready, fifo_empty, fast_win, push, pop, hit;

  assign fast_stall = (starv_q == SW'(STARVE_LIMIT));
  assign slow_ready = (count_q < CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign fast_win   = bus.fast_valid && !fast_stall;
  assign push       = bus.slow_valid && slow_ready;
  assign pop        = !fast_win && !fifo_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    if (push) begin
      wr_ptr_d          = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      valid_d[wr_ptr_q] = 1'b1;
    end
    if (pop) begin
      rd_ptr_d          = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      valid_d[rd_ptr_q] = 1'b0;
    end
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  // The head waits only while the fast path keeps winning; a stall forces a pop.
  always_comb begin
    starv_d = starv_q;
    if (fifo_empty || pop)              starv_d = '0;
    else if (fast_win && !fast_stall)   starv_d = starv_q + SW'(1);
  end

  always_comb begin
    hit = f_wen_q && (f_rd_q == bus.chk_rd);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (valid_q[i] && (mem_rd_q[i] == bus.chk_rd)) hit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd_q[wr_ptr_q]    <= bus.slow_rd;
      mem_data_q[wr_ptr_q]  <= bus.slow_data;
      mem_flags_q[wr_ptr_q] <= bus.slow_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      valid_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      starv_q     <= '0;
      out_valid_q <= 1'b0;
      f_wen_q     <= 1'b0;
      f_rd_q      <= '0;
      f_w_data_q  <= '0;
      flags_q     <= '0;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starv_q  <= starv_d;
      if (fast_win) begin
        out_valid_q <= 1'b1;
        f_wen_q     <= bus.fast_fwe;
        f_rd_q      <= bus.fast_rd;
        f_w_data_q  <= bus.fast_data;
        flags_q     <= bus.fast_flags;
      end else if (!fifo_empty) begin
        out_valid_q <= 1'b1;
        f_wen_q     <= 1'b1;
        f_rd_q      <= mem_rd_q[rd_ptr_q];
        f_w_data_q  <= mem_data_q[rd_ptr_q];
        flags_q     <= mem_flags_q[rd_ptr_q];
      end else begin
        out_valid_q <= 1'b0;
        f_wen_q     <= 1'b0;
        flags_q     <= '0;
      end
    end
  end

  assign bus.fast_stall = fast_stall;
  assign bus.slow_ready = slow_ready;
  assign bus.chk_hit    = hit;
  assign bus.f_wen      = f_wen_q;
  assign bus.f_rd       = f_rd_q;
  assign bus.f_w_data   = f_w_data_q;
  assign bus.f_NV       = out_valid_q && flags_q[4];
  assign bus.f_DZ       = out_valid_q && flags_q[3];
  assign bus.f_OF       = out_valid_q && flags_q[2];
  assign bus.f_UF       = out_valid_q && flags_q[1];
  assign bus.f_NX       = out_valid_q && flags_q[0];
endmodule

// File: tb/tb_f_wb_arbiter.sv
// Directed bench for f_wb_arbiter: each cycle's expected writeback is queued when the
// stimulus is driven and popped when the registered output appears one edge later.
`timescale 1ns/1ps
module tb_f_wb_arbiter;
  logic clk = 1'b0;
  logic n_rst;
  int   vectors = 0;
  int   miscompares = 0;

  logic [42:0] exp_q[$];
  logic [31:0] fdat [10];
  logic [31:0] sdat [3];

  f_wb_arbiter_if bus();

  f_wb_arbiter dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: got %h want %h", tag, obs, expv);
    end
  endtask

  function automatic logic [42:0] wb(input logic wen, input logic [4:0] rd,
                                     input logic [31:0] d, input logic [4:0] fl);
    return {wen, rd, d, fl};
  endfunction

  function automatic logic [42:0] observed();
    return {bus.f_wen, bus.f_rd, bus.f_w_data,
            bus.f_NV, bus.f_DZ, bus.f_OF, bus.f_UF, bus.f_NX};
  endfunction

  task automatic check_out(input string tag);
    logic [42:0] e;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s: got writeback %h want none (scoreboard empty)", tag, observed());
    end else begin
      e = exp_q.pop_front();
      chk(tag, 64'(observed()), 64'(e));
    end
  endtask

  task automatic check_idle(input string tag);
    chk(tag, 64'({bus.f_wen, bus.f_NV, bus.f_DZ, bus.f_OF, bus.f_UF, bus.f_NX}), 64'(0));
  endtask

  task automatic idle_inputs();
    bus.fast_valid = 1'b0;
    bus.fast_fwe   = 1'b0;
    bus.fast_rd    = '0;
    bus.fast_data  = '0;
    bus.fast_flags = '0;
    bus.slow_valid = 1'b0;
    bus.slow_rd    = '0;
    bus.slow_data  = '0;
    bus.slow_flags = '0;
  endtask

  initial begin
    logic [4:0]  srd;
    logic [4:0]  sfl;
    logic [31:0] rdat;
    int          f;

    for (int i = 0; i < 10; i++) fdat[i] = $urandom_range(32'hFFFF_FFFF, 0);
    for (int i = 0; i < 3; i++)  sdat[i] = $urandom_range(32'hFFFF_FFFF, 0);

    // reset
    idle_inputs();
    bus.chk_rd = '0;
    n_rst = 1'b1;
    tick();
    tick();
    n_rst = 1'b0;
    check_idle("reset_out");
    chk("reset_rd", 64'(bus.f_rd), 64'(0));
    chk("reset_data", 64'(bus.f_w_data), 64'(0));
    chk("reset_ready", 64'(bus.slow_ready), 64'(1));
    chk("reset_stall", 64'(bus.fast_stall), 64'(0));
    chk("reset_hit", 64'(bus.chk_hit), 64'(0));

    // single fast result, latency 1
    bus.fast_valid = 1'b1;
    bus.fast_fwe   = 1'b1;
    bus.fast_rd    = 5'd5;
    bus.fast_data  = 32'h3F80_0000;
    bus.fast_flags = 5'b00001;
    exp_q.push_back(wb(1'b1, 5'd5, 32'h3F80_0000, 5'b00001));
    tick();
    idle_inputs();
    check_out("fast_rd5");
    tick();
    check_idle("fast_after");

    // single slow result, latency 2, hazard visible until written
    bus.slow_valid = 1'b1;
    bus.slow_rd    = 5'd7;
    bus.slow_data  = 32'h4000_0000;
    bus.slow_flags = 5'b00010;
    bus.chk_rd     = 5'd7;
    #1;
    chk("slow_hit_before", 64'(bus.chk_hit), 64'(0));
    tick();
    idle_inputs();
    check_idle("slow_t1_out");
    chk("slow_hit_queued", 64'(bus.chk_hit), 64'(1));
    exp_q.push_back(wb(1'b1, 5'd7, 32'h4000_0000, 5'b00010));
    tick();
    check_out("slow_rd7");
    chk("slow_hit_write", 64'(bus.chk_hit), 64'(1));
    tick();
    check_idle("slow_after");
    chk("slow_hit_done", 64'(bus.chk_hit), 64'(0));

    // fill FIFO under continuous fast traffic; starvation stall on the 9th cycle
    bus.fast_valid = 1'b1;
    bus.fast_fwe   = 1'b1;
    bus.fast_flags = '0;
    for (int k = 0; k < 11; k++) begin
      f = (k > 9) ? 9 : k;
      bus.fast_rd   = 5'(f + 1);
      bus.fast_data = fdat[f];
      srd = (k == 0) ? 5'd10 : (k == 1) ? 5'd11 : 5'd12;
      sfl = (k == 0) ? 5'b00100 : (k == 1) ? 5'b01000 : 5'b00001;
      bus.slow_valid = 1'b1;
      bus.slow_rd    = srd;
      bus.slow_data  = sdat[(k > 2) ? 2 : k];
      bus.slow_flags = sfl;
      if (k == 1)  chk("ready_one", 64'(bus.slow_ready), 64'(1));
      if (k == 2)  chk("ready_full", 64'(bus.slow_ready), 64'(0));
      if (k == 8)  chk("stall_pre", 64'(bus.fast_stall), 64'(0));
      if (k == 9)  chk("stall_on", 64'(bus.fast_stall), 64'(1));
      if (k == 10) begin
        chk("stall_off", 64'(bus.fast_stall), 64'(0));
        chk("ready_after_pop", 64'(bus.slow_ready), 64'(1));
      end
      if (k == 9) exp_q.push_back(wb(1'b1, 5'd10, sdat[0], 5'b00100));
      else        exp_q.push_back(wb(1'b1, 5'(f + 1), fdat[f], 5'b00000));
      tick();
      check_out($sformatf("burst_%0d", k));
    end
    idle_inputs();
    bus.chk_rd = 5'd12;
    #1;
    chk("ready_refull", 64'(bus.slow_ready), 64'(0));
    chk("hit_rd12", 64'(bus.chk_hit), 64'(1));
    exp_q.push_back(wb(1'b1, 5'd11, sdat[1], 5'b01000));
    tick();
    check_out("drain_b");
    exp_q.push_back(wb(1'b1, 5'd12, sdat[2], 5'b00001));
    tick();
    check_out("drain_c");
    tick();
    check_idle("drain_idle");
    chk("hit_rd12_done", 64'(bus.chk_hit), 64'(0));

    // flags-only fast op
    rdat = $urandom_range(32'hFFFF_FFFF, 0);
    bus.fast_valid = 1'b1;
    bus.fast_fwe   = 1'b0;
    bus.fast_rd    = 5'd3;
    bus.fast_data  = rdat;
    bus.fast_flags = 5'b10000;
    exp_q.push_back(wb(1'b0, 5'd3, rdat, 5'b10000));
    tick();
    idle_inputs();
    check_out("flags_only");
    tick();
    check_idle("flags_only_after");

    // reset with two entries queued and a write in the output stage
    bus.fast_valid = 1'b1;
    bus.fast_fwe   = 1'b1;
    bus.fast_rd    = 5'd20;
    bus.fast_data  = fdat[0];
    bus.slow_valid = 1'b1;
    bus.slow_rd    = 5'd21;
    bus.slow_data  = sdat[0];
    exp_q.push_back(wb(1'b1, 5'd20, fdat[0], 5'b00000));
    tick();
    check_out("pre_rst_a");
    bus.fast_rd    = 5'd23;
    bus.fast_data  = fdat[1];
    bus.slow_rd    = 5'd22;
    bus.slow_data  = sdat[1];
    exp_q.push_back(wb(1'b1, 5'd23, fdat[1], 5'b00000));
    tick();
    check_out("pre_rst_b");
    chk("pre_rst_full", 64'(bus.slow_ready), 64'(0));
    idle_inputs();
    n_rst = 1'b1;
    tick();
    check_idle("rst_out");
    chk("rst_rd", 64'(bus.f_rd), 64'(0));
    chk("rst_ready", 64'(bus.slow_ready), 64'(1));
    chk("rst_stall", 64'(bus.fast_stall), 64'(0));
    for (int r = 0; r < 32; r++) begin
      bus.chk_rd = 5'(r);
      #0.25;
      chk($sformatf("rst_hit_%0d", r), 64'(bus.chk_hit), 64'(0));
    end
    n_rst = 1'b0;
    tick();
    check_idle("post_rst_idle");
    chk("post_rst_ready", 64'(bus.slow_ready), 64'(1));
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
